// File: rtl/eth_mdio_phy.sv
// Clause 22 MDIO responder (PHY side): decodes MDC-clocked frames and serves a small register file.
// Read data drives from the second turnaround bit; writes commit on the last data bit; no backpressure.
module eth_mdio_phy #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0007,
    parameter logic [15:0] PHY_ID2      = 16'hC0F1,
    parameter logic [15:0] STATUS_VAL   = 16'h782D
) (
    input  logic        Clk,
    input  logic        Rstn,
    input  logic        MDIO_In,
    output logic        MDIO_Out,
    output logic        MDIO_Oe,
    output logic        Wr_Strobe,
    output logic [4:0]  Wr_Addr,
    output logic [15:0] Wr_Data,
    output logic        Frame_Err
);

    localparam logic [5:0]  LP_PRE_MIN  = 6'(PREAMBLE_MIN);
    localparam logic [15:0] LP_REG0_RST = 16'h3100;
    localparam logic [15:0] LP_REG4_RST = 16'h01E1;

    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA, S_SKIP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_pre, w_pre_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic        r_op_msb, w_op_msb_nxt;
    logic        r_is_rd, w_is_rd_nxt;
    logic        r_ta1, w_ta1_nxt;
    logic [4:0]  r_phyad, w_phyad_nxt;
    logic [4:0]  r_regad, w_regad_nxt;
    logic [15:0] r_shift, w_shift_nxt;
    logic        r_out, w_out_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_ferr, w_ferr_nxt;
    logic        r_wr_stb;
    logic [4:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic [15:0] r_reg0;
    logic [15:0] r_rw [4];
    logic        w_writable;
    logic        w_commit;
    logic [15:0] w_wdata;
    logic [15:0] w_rd_data;

    assign MDIO_Out  = r_out;
    assign MDIO_Oe   = r_oe;
    assign Wr_Strobe = r_wr_stb;
    assign Wr_Addr   = r_wr_addr;
    assign Wr_Data   = r_wr_data;
    assign Frame_Err = r_ferr;

    always_comb begin
        w_rd_data = 16'h0000;
        case (r_regad)
            5'd0:                   w_rd_data = r_reg0;
            5'd1:                   w_rd_data = STATUS_VAL;
            5'd2:                   w_rd_data = PHY_ID1;
            5'd3:                   w_rd_data = PHY_ID2;
            5'd4, 5'd5, 5'd6, 5'd7: w_rd_data = r_rw[r_regad[1:0]];
            default:                w_rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        w_writable = (r_regad == 5'd0) || (r_regad[4:2] == 3'b001);
        w_wdata    = {r_shift[14:0], MDIO_In};
        w_commit   = (r_state == S_WDATA) && (r_cnt == 5'd15) && w_writable;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pre_nxt    = r_pre;
        w_cnt_nxt    = r_cnt;
        w_op_msb_nxt = r_op_msb;
        w_is_rd_nxt  = r_is_rd;
        w_ta1_nxt    = r_ta1;
        w_phyad_nxt  = r_phyad;
        w_regad_nxt  = r_regad;
        w_shift_nxt  = r_shift;
        w_out_nxt    = 1'b1;
        w_oe_nxt     = 1'b0;
        w_ferr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MDIO_In) begin
                    w_pre_nxt = (r_pre == 6'd63) ? 6'd63 : r_pre + 6'd1;
                end else begin
                    w_pre_nxt = 6'd0;
                    if (r_pre >= LP_PRE_MIN) w_state_nxt = S_ST;
                end
            end
            S_ST: begin
                if (MDIO_In) begin
                    w_state_nxt = S_OP;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_OP: begin
                if (r_cnt == 5'd0) begin
                    w_op_msb_nxt = MDIO_In;
                    w_cnt_nxt    = 5'd1;
                end else if (r_op_msb != MDIO_In) begin
                    w_is_rd_nxt = r_op_msb;
                    w_state_nxt = S_PHYAD;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_PHYAD: begin
                w_phyad_nxt = {r_phyad[3:0], MDIO_In};
                w_cnt_nxt   = (r_cnt == 5'd4) ? 5'd0 : r_cnt + 5'd1;
                if (r_cnt == 5'd4) w_state_nxt = S_REGAD;
            end
            S_REGAD: begin
                w_regad_nxt = {r_regad[3:0], MDIO_In};
                w_cnt_nxt   = r_cnt + 5'd1;
                if (r_cnt == 5'd4) begin
                    // Foreign frames are swallowed bit for bit so the next preamble lines up
                    if (r_phyad == PHY_ADDR) begin
                        w_state_nxt = S_TA;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_state_nxt = S_SKIP;
                        w_cnt_nxt   = 5'd17;
                    end
                end
            end
            S_TA: begin
                if (r_is_rd) begin
                    w_oe_nxt    = 1'b1;
                    w_out_nxt   = 1'b0;
                    w_shift_nxt = w_rd_data;
                    w_state_nxt = S_RDATA;
                    w_cnt_nxt   = 5'd0;
                end else if (r_cnt == 5'd0) begin
                    w_ta1_nxt = MDIO_In;
                    w_cnt_nxt = 5'd1;
                end else if (r_ta1 && !MDIO_In) begin
                    w_state_nxt = S_WDATA;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_SKIP;
                    w_cnt_nxt   = 5'd15;
                end
            end
            S_RDATA: begin
                if (r_cnt == 5'd16) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_oe_nxt    = 1'b1;
                    w_out_nxt   = r_shift[15];
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
            end
            S_WDATA: begin
                w_shift_nxt = w_wdata;
                w_cnt_nxt   = r_cnt + 5'd1;
                if (r_cnt == 5'd15) w_state_nxt = S_IDLE;
            end
            S_SKIP: begin
                if (r_cnt == 5'd0) w_state_nxt = S_IDLE;
                else               w_cnt_nxt   = r_cnt - 5'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            r_pre     <= 6'd0;
            r_cnt     <= 5'd0;
            r_op_msb  <= 1'b0;
            r_is_rd   <= 1'b0;
            r_ta1     <= 1'b0;
            r_phyad   <= 5'd0;
            r_regad   <= 5'd0;
            r_shift   <= 16'd0;
            r_out     <= 1'b1;
            r_oe      <= 1'b0;
            r_ferr    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 16'd0;
        end else begin
            r_pre    <= w_pre_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op_msb <= w_op_msb_nxt;
            r_is_rd  <= w_is_rd_nxt;
            r_ta1    <= w_ta1_nxt;
            r_phyad  <= w_phyad_nxt;
            r_regad  <= w_regad_nxt;
            r_shift  <= w_shift_nxt;
            r_out    <= w_out_nxt;
            r_oe     <= w_oe_nxt;
            r_ferr   <= w_ferr_nxt;
            r_wr_stb <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_regad;
                r_wr_data <= w_wdata;
            end
        end
    end

    // Control bit 15 is a soft reset: it restores the R/W registers and never reads back as 1
    always_ff @(posedge Clk) begin
        if (!Rstn || (w_commit && (r_regad == 5'd0) && w_wdata[15])) begin
            r_reg0  <= LP_REG0_RST;
            r_rw[0] <= LP_REG4_RST;
            r_rw[1] <= 16'd0;
            r_rw[2] <= 16'd0;
            r_rw[3] <= 16'd0;
        end else if (w_commit) begin
            if (r_regad == 5'd0) r_reg0 <= w_wdata;
            else                 r_rw[r_regad[1:0]] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_eth_mdio_phy.sv
// Bench for eth_mdio_phy: drives MDIO frames on the falling edge, scoreboards the PHY's
// read data, write strobes and frame errors with their exact MDC edge.
module tb_eth_mdio_phy;

    logic        Clk = 1'b0;
    logic        Rstn = 1'b0;
    logic        MDIO_In = 1'b1;
    logic        MDIO_Out;
    logic        MDIO_Oe;
    logic        Wr_Strobe;
    logic [4:0]  Wr_Addr;
    logic [15:0] Wr_Data;
    logic        Frame_Err;

    eth_mdio_phy dut (
        .Clk       (Clk),
        .Rstn      (Rstn),
        .MDIO_In   (MDIO_In),
        .MDIO_Out  (MDIO_Out),
        .MDIO_Oe   (MDIO_Oe),
        .Wr_Strobe (Wr_Strobe),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Frame_Err (Frame_Err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    localparam int K_RD    = 1;
    localparam int K_WR    = 2;
    localparam int K_ERR   = 3;
    localparam int K_ABORT = 4;

    typedef struct {
        int          kind;
        int          t;
        logic [4:0]  addr;
        logic [15:0] dat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame bit i (0 = first start bit) is driven while cyc == X0+i and sampled
    // by the edge that makes cyc == X0+i+1; 'off' places the expected event.
    task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                              input int kind, input int off, input logic [15:0] edat,
                              input int rst_at);
        logic [31:0] bits;
        exp_t        e;
        bits = {2'b01, op, phy, ra, ta, wd};
        for (int i = 0; i < npre; i++) begin
            @(negedge Clk);
            MDIO_In = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            if (i == 0 && kind != 0) begin
                e.kind = kind;
                e.t    = cyc + off;
                e.addr = ra;
                e.dat  = edat;
                q.push_back(e);
            end
            MDIO_In = bits[31-i];
            Rstn    = (i == rst_at) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic rd(input logic [4:0] ra, input logic [15:0] exp_dat);
        send_frame(32, 2'b10, 5'd1, ra, 2'b11, 16'hFFFF, K_RD, 15, exp_dat, -1);
    endtask

    task automatic wr(input logic [4:0] ra, input logic [15:0] d);
        send_frame(32, 2'b01, 5'd1, ra, 2'b10, d, K_WR, 32, d, -1);
    endtask

    logic        rd_active = 1'b0;
    int          nb = 0;
    logic [15:0] sh = 16'd0;

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (!Rstn) begin
                chk("reset_outputs", {MDIO_Oe, MDIO_Out, Wr_Strobe, Frame_Err, Wr_Addr, Wr_Data},
                    {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0});
                if (rd_active) begin
                    if (q.size() == 0) chk("abort_expected", 0, 1);
                    else begin
                        e = q.pop_front();
                        chk("abort_kind", e.kind, K_ABORT);
                    end
                    rd_active = 1'b0;
                end
                continue;
            end
            if (Frame_Err) begin
                if (q.size() == 0) chk("unexpected_frame_err", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("err_kind", e.kind, K_ERR);
                    chk("err_cycle", cyc, e.t);
                end
            end
            if (Wr_Strobe) begin
                if (q.size() == 0) chk("unexpected_wr_strobe", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("wr_kind", e.kind, K_WR);
                    chk("wr_cycle", cyc, e.t);
                    chk("wr_addr", Wr_Addr, e.addr);
                    chk("wr_data", Wr_Data, e.dat);
                end
            end
            if (rd_active) begin
                if (nb < 16) begin
                    chk("rd_oe_held", MDIO_Oe, 1);
                    sh = {sh[14:0], MDIO_Out};
                    nb++;
                end else begin
                    chk("rd_release", {MDIO_Oe, MDIO_Out}, 2'b01);
                    if (q.size() == 0) chk("rd_expected", 0, 1);
                    else begin
                        e = q.pop_front();
                        chk("rd_kind", e.kind, K_RD);
                        chk("rd_data", sh, e.dat);
                    end
                    rd_active = 1'b0;
                end
            end else if (MDIO_Oe) begin
                chk("ta_drive_low", MDIO_Out, 0);
                if (q.size() == 0) chk("unexpected_oe", 1, 0);
                else begin
                    chk("rd_start_kind", (q[0].kind == K_RD) || (q[0].kind == K_ABORT), 1);
                    chk("rd_start_cycle", cyc, q[0].t);
                end
                rd_active = 1'b1;
                nb        = 0;
                sh        = 16'd0;
            end
        end
    end

    initial begin
        Rstn    = 1'b0;
        MDIO_In = 1'b1;
        repeat (3) @(negedge Clk);
        Rstn = 1'b1;

        rd(5'd2, 16'h0007);
        rd(5'd3, 16'hC0F1);
        rd(5'd1, 16'h782D);

        wr(5'd4, 16'hA5A5);
        rd(5'd4, 16'hA5A5);

        wr(5'd5, 16'h1234);
        wr(5'd0, 16'h8000);
        rd(5'd0, 16'h3100);
        rd(5'd5, 16'h0000);
        rd(5'd4, 16'h01E1);

        // foreign PHY address: silent, then a normal frame
        send_frame(32, 2'b10, 5'd2, 5'd2, 2'b11, 16'hFFFF, 0, 0, 16'h0, -1);
        rd(5'd3, 16'hC0F1);

        // 31-bit preamble: ignored without error
        send_frame(31, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, 0, 0, 16'h0, -1);
        rd(5'd2, 16'h0007);

        // writes to read-only and unmapped addresses produce no strobe
        send_frame(32, 2'b01, 5'd1, 5'd2, 2'b10, 16'hDEAD, 0, 0, 16'h0, -1);
        send_frame(32, 2'b01, 5'd1, 5'd9, 2'b10, 16'hBEEF, 0, 0, 16'h0, -1);
        rd(5'd2, 16'h0007);
        rd(5'd9, 16'h0000);

        // OP=11 and bad write turnaround
        send_frame(32, 2'b11, 5'd1, 5'd2, 2'b11, 16'hFFFF, K_ERR, 4, 16'h0, -1);
        send_frame(32, 2'b01, 5'd1, 5'd6, 2'b11, 16'h5555, K_ERR, 16, 16'h0, -1);
        rd(5'd6, 16'h0000);

        // reset during read data, then everything back at reset values
        wr(5'd7, 16'hBEEF);
        wr(5'd4, 16'h0F0F);
        rd(5'd7, 16'hBEEF);
        send_frame(32, 2'b10, 5'd1, 5'd7, 2'b11, 16'hFFFF, K_ABORT, 15, 16'h0, 25);
        rd(5'd7, 16'h0000);
        rd(5'd0, 16'h3100);
        rd(5'd4, 16'h01E1);

        repeat (40) @(negedge Clk) MDIO_In = 1'b1;
        chk("scoreboard_drained", q.size(), 0);
        chk("no_read_in_flight", rd_active, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
